// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset controller. Steps the shared memory/ALU datapath through
// FETCH/DECODE/EXEC/MEM/WB for R-type(0), lw(35), sw(43) and beq(4). It also
// handles memory wait states, counts retired instructions, and traps on an
// illegal opcode or a memory timeout.
//
// Ports
//   i_clk, i_rst_n   clock (rising edge), synchronous active-low reset
//   i_en             run enable, looked at only in FETCH
//   i_opcode         instr[31:26] from IR, captured in DECODE
//   i_mem_ready      memory completes the access this cycle
//   o_pc_write       PC <= PC+4
//   o_ir_write       IR <= memory data
//   o_mem_read       memory read request
//   o_mem_write      memory write request
//   o_reg_dst        1: rd, 0: rt
//   o_alu_src        1: sign-extended immediate, 0: rt
//   o_mem_to_reg     1: memory data, 0: ALU result
//   o_reg_write      register file write
//   o_branch         beq compare/branch enable
//   o_alu_op         00 add, 01 sub, 10 funct-decoded
//   o_state          current state (FETCH=0 .. TRAP=5)
//   o_instr_cnt      retired-instruction count (wraps)
//   o_illegal_op     sticky illegal-opcode trap flag
//   o_mem_timeout    sticky memory-timeout trap flag
module multicycle_control #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [5:0]       i_opcode,
    input  logic             i_mem_ready,
    output logic             o_pc_write,
    output logic             o_ir_write,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic             o_reg_dst,
    output logic             o_alu_src,
    output logic             o_mem_to_reg,
    output logic             o_reg_write,
    output logic             o_branch,
    output logic [1:0]       o_alu_op,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_instr_cnt,
    output logic             o_illegal_op,
    output logic             o_mem_timeout
);

    localparam int unsigned WAIT_W = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t              r_state;
    logic [5:0]          r_opcode_q;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]    r_instr_cnt;
    logic                r_illegal_op;
    logic                r_mem_timeout;

    logic w_op_legal;
    logic w_wait_expired;

    assign w_op_legal     = (i_opcode == OP_RTYPE) || (i_opcode == OP_LW) ||
                            (i_opcode == OP_SW)    || (i_opcode == OP_BEQ);
    assign w_wait_expired = (r_wait_cnt == WAIT_W'(WAIT_LIMIT));

    // State, captured opcode, wait counter, retire counter and sticky trap flags
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_FETCH;
            r_opcode_q    <= 6'd0;
            r_wait_cnt    <= '0;
            r_instr_cnt   <= '0;
            r_illegal_op  <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!i_en) begin
                        // Idle: no request outstanding, so nothing to time out on
                        r_wait_cnt <= '0;
                    end else if (i_mem_ready) begin
                        r_state    <= S_DECODE;
                        r_wait_cnt <= '0;
                    end else if (w_wait_expired) begin
                        r_state       <= S_TRAP;
                        r_mem_timeout <= 1'b1;
                        r_wait_cnt    <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    r_opcode_q <= i_opcode;
                    r_wait_cnt <= '0;
                    if (w_op_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state      <= S_TRAP;
                        r_illegal_op <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_wait_cnt <= '0;
                    case (r_opcode_q)
                        OP_RTYPE:     r_state <= S_WB;
                        OP_LW, OP_SW: r_state <= S_MEM;
                        OP_BEQ: begin
                            r_state     <= S_FETCH;
                            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
                        end
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (i_mem_ready) begin
                        r_wait_cnt <= '0;
                        if (r_opcode_q == OP_LW) begin
                            r_state <= S_WB;
                        end else begin
                            r_state     <= S_FETCH;
                            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
                        end
                    end else if (w_wait_expired) begin
                        r_state       <= S_TRAP;
                        r_mem_timeout <= 1'b1;
                        r_wait_cnt    <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    r_state     <= S_FETCH;
                    r_wait_cnt  <= '0;
                    r_instr_cnt <= r_instr_cnt + CNT_W'(1);
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state    <= S_FETCH;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    // Control decode from state and captured opcode; forced low while reset is held.
    // The fetch request follows en, and IR/PC updates are gated on the memory handshake.
    always_comb begin
        o_pc_write   = 1'b0;
        o_ir_write   = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_reg_dst    = 1'b0;
        o_alu_src    = 1'b0;
        o_mem_to_reg = 1'b0;
        o_reg_write  = 1'b0;
        o_branch     = 1'b0;
        o_alu_op     = 2'b00;
        if (i_rst_n) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_read = i_en;
                    o_ir_write = i_en && i_mem_ready;
                    o_pc_write = i_en && i_mem_ready;
                end
                S_EXEC: begin
                    case (r_opcode_q)
                        OP_RTYPE: o_alu_op = 2'b10;
                        OP_LW, OP_SW: begin
                            o_alu_src = 1'b1;
                            o_alu_op  = 2'b00;
                        end
                        OP_BEQ: begin
                            o_alu_op = 2'b01;
                            o_branch = 1'b1;
                        end
                        default: o_alu_op = 2'b00;
                    endcase
                end
                S_MEM: begin
                    o_mem_read  = (r_opcode_q == OP_LW);
                    o_mem_write = (r_opcode_q == OP_SW);
                end
                S_WB: begin
                    o_reg_write  = 1'b1;
                    o_reg_dst    = (r_opcode_q == OP_RTYPE);
                    o_mem_to_reg = (r_opcode_q == OP_LW);
                end
                default: o_alu_op = 2'b00;
            endcase
        end
    end

    assign o_state       = r_state;
    assign o_instr_cnt   = r_instr_cnt;
    assign o_illegal_op  = r_illegal_op;
    assign o_mem_timeout = r_mem_timeout;

endmodule
